// File: rtl/dmem_load_unit_pkg.sv
// Shared definitions for the DMEM load unit: funct3 load encodings,
// FSM state encoding and the word size in bytes.
// Optional feature macro: DMEM_LOAD_SPLIT_EN (adds ISSUE2/WAIT2 states).
package dmem_load_unit_pkg;

    localparam int WORD_BYTES = 4;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        WAIT   = 3'd2,
        RESP   = 3'd3
`ifdef DMEM_LOAD_SPLIT_EN
        ,
        ISSUE2 = 3'd4,
        WAIT2  = 3'd5
`endif
    } state_t;

endpackage

// File: rtl/dmem_load_unit_if.sv
// Bus bundle between the load unit (slave) and its environment (master):
// execute-stage request, DMEM read port and writeback response.
//
// Handshakes: a transfer happens on a rising clk edge where both valid and
// ready are high. The producer keeps valid and its payload stable until that
// edge; ready may change freely and never depends on valid in the same cycle.
interface dmem_load_unit_if #(
    parameter int bits            = 32,
    parameter int addr_width_DMEM = 10
);
    logic                       req_valid;
    logic                       req_ready;
    logic [bits-1:0]            req_addr;
    logic [2:0]                 req_funct3;
    logic                       mem_en;
    logic [addr_width_DMEM-3:0] mem_addr;
    logic [bits-1:0]            mem_rdata;
    logic                       resp_valid;
    logic                       resp_ready;
    logic [bits-1:0]            resp_data;
    logic                       resp_error;

    modport master (
        output req_valid, req_addr, req_funct3, mem_rdata, resp_ready,
        input  req_ready, mem_en, mem_addr, resp_valid, resp_data, resp_error
    );

    modport slave (
        input  req_valid, req_addr, req_funct3, mem_rdata, resp_ready,
        output req_ready, mem_en, mem_addr, resp_valid, resp_data, resp_error
    );
endinterface

// File: rtl/dmem_load_unit_load_extract.sv
// Combinational byte/halfword/word selection and sign/zero extension of a
// DMEM word according to the load funct3 and the byte offset in the word.
module dmem_load_unit_load_extract
    import dmem_load_unit_pkg::*;
#(
    parameter int bits = 32
) (
    input  logic [bits-1:0] word,
    input  logic [1:0]      offset,
    input  logic [2:0]      funct3,
    output logic [bits-1:0] data
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte/half, then extend according to the load type.
    always_comb begin
        byte_sel = word[{offset, 3'b000} +: 8];
        half_sel = word[{offset[1], 4'b0000} +: 16];
        data     = '0;
        case (funct3)
            F3_LB:   data = {{(bits-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  data = {{(bits-8){1'b0}}, byte_sel};
            F3_LH:   data = {{(bits-16){half_sel[15]}}, half_sel};
            F3_LHU:  data = {{(bits-16){1'b0}}, half_sel};
            F3_LW:   data = word;
            default: data = '0;
        endcase
    end
endmodule

// File: rtl/dmem_load_unit.sv
// DMEM load unit: accepts one load at a time, reads the word from a
// synchronous DMEM with MEM_LATENCY cycles of read latency, extracts and
// extends the result and hands it to writeback over a valid/ready handshake.
// Optional feature macro: DMEM_LOAD_SPLIT_EN (misaligned loads read two words).
module dmem_load_unit
    import dmem_load_unit_pkg::*;
#(
    parameter int bits            = 32,
    parameter int addr_width_DMEM = 10,
    parameter int MEM_LATENCY     = 1
) (
    input  logic              clk,
    input  logic              async_reset,
    dmem_load_unit_if.slave   bus,
    output state_t            state_dbg
);
    localparam int WA_W  = addr_width_DMEM - 2;
    localparam int OFF_W = $clog2(WORD_BYTES);
    localparam int CNT_W = 2;

    state_t            state_q, state_d;
    logic [OFF_W-1:0]  off_q;
    logic [2:0]        f3_q;
    logic [WA_W-1:0]   waddr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [bits-1:0]   data_q;
    logic              err_q;
    logic              accept, range_err, illegal, misaligned, req_err, cnt_zero;
    logic [bits-1:0]   ext_word, ext_data;
    logic [OFF_W-1:0]  ext_off;
`ifdef DMEM_LOAD_SPLIT_EN
    logic              split_q;
    logic [bits-1:0]   w0_q;
    logic [bits-1:0]   pair_low;
`endif

    assign accept    = (state_q == IDLE) && bus.req_valid;
    assign cnt_zero  = (cnt_q == '0);
    assign state_dbg = state_q;

    // Classify the incoming request: range, funct3 legality and alignment.
    always_comb begin
        range_err  = |bus.req_addr[bits-1:addr_width_DMEM];
        illegal    = 1'b0;
        misaligned = 1'b0;
        case (bus.req_funct3)
            F3_LB, F3_LBU: misaligned = 1'b0;
            F3_LH, F3_LHU: misaligned = bus.req_addr[0];
            F3_LW:         misaligned = |bus.req_addr[1:0];
            default:       illegal    = 1'b1;
        endcase
`ifdef DMEM_LOAD_SPLIT_EN
        // A split access is only illegal if the second word falls off the end.
        req_err = range_err | illegal | (misaligned & (&bus.req_addr[addr_width_DMEM-1:OFF_W]));
`else
        req_err = range_err | illegal | misaligned;
`endif
    end

    // Next-state logic of the load FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (accept) state_d = req_err ? RESP : ISSUE;
            ISSUE: state_d = WAIT;
`ifdef DMEM_LOAD_SPLIT_EN
            WAIT:   if (cnt_zero) state_d = split_q ? ISSUE2 : RESP;
            ISSUE2: state_d = WAIT2;
            WAIT2:  if (cnt_zero) state_d = RESP;
`else
            WAIT:  if (cnt_zero) state_d = RESP;
`endif
            RESP:  if (bus.resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus outputs decoded from the current state and the latched request.
    always_comb begin
        bus.req_ready  = (state_q == IDLE);
        bus.resp_valid = (state_q == RESP);
        bus.resp_data  = data_q;
        bus.resp_error = err_q;
        bus.mem_en     = 1'b0;
        bus.mem_addr   = '0;
        if (state_q == ISSUE) begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = waddr_q;
        end
`ifdef DMEM_LOAD_SPLIT_EN
        if (state_q == ISSUE2) begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = waddr_q + WA_W'(1);
        end
`endif
    end

    // Extractor input: raw word, or the low word of the shifted pair when split.
    always_comb begin
`ifdef DMEM_LOAD_SPLIT_EN
        pair_low = bits'({bus.mem_rdata, w0_q} >> {off_q, 3'b000});
        ext_word = split_q ? pair_low : bus.mem_rdata;
        ext_off  = split_q ? '0 : off_q;
`else
        ext_word = bus.mem_rdata;
        ext_off  = off_q;
`endif
    end

    dmem_load_unit_load_extract #(.bits(bits)) u_load_extract (
        .word   (ext_word),
        .offset (ext_off),
        .funct3 (f3_q),
        .data   (ext_data)
    );

    // State register, request latch, latency counter and result capture.
    always_ff @(posedge clk) begin
        if (async_reset) begin
            state_q <= IDLE;
            off_q   <= '0;
            f3_q    <= '0;
            waddr_q <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
`ifdef DMEM_LOAD_SPLIT_EN
            split_q <= 1'b0;
            w0_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                off_q   <= bus.req_addr[OFF_W-1:0];
                f3_q    <= bus.req_funct3;
                waddr_q <= bus.req_addr[addr_width_DMEM-1:OFF_W];
                err_q   <= req_err;
                data_q  <= '0;
`ifdef DMEM_LOAD_SPLIT_EN
                split_q <= misaligned;
`endif
            end
`ifdef DMEM_LOAD_SPLIT_EN
            if (state_q == ISSUE || state_q == ISSUE2)
                cnt_q <= CNT_W'(MEM_LATENCY - 1);
            else if ((state_q == WAIT || state_q == WAIT2) && !cnt_zero)
                cnt_q <= cnt_q - CNT_W'(1);
            if (state_q == WAIT && cnt_zero) begin
                if (split_q) w0_q <= bus.mem_rdata;
                else         data_q <= ext_data;
            end
            if (state_q == WAIT2 && cnt_zero)
                data_q <= ext_data;
`else
            if (state_q == ISSUE)
                cnt_q <= CNT_W'(MEM_LATENCY - 1);
            else if (state_q == WAIT && !cnt_zero)
                cnt_q <= cnt_q - CNT_W'(1);
            if (state_q == WAIT && cnt_zero)
                data_q <= ext_data;
`endif
        end
    end
endmodule

// File: tb/tb_dmem_load_unit.sv
// Bench for dmem_load_unit: two instances (MEM_LATENCY 1 and 3) with
// pipelined DMEM models, directed and randomized loads against a
// byte-addressed reference model.
module tb_dmem_load_unit;
    import dmem_load_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic [2:0]  req_funct3 = '0;
    logic        resp_ready = 1'b0;

    logic [31:0] mem [256];
    logic [2:0]  legal [5] = '{F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    dmem_load_unit_if #(.bits(32), .addr_width_DMEM(10)) bus1 ();
    dmem_load_unit_if #(.bits(32), .addr_width_DMEM(10)) bus3 ();
    state_t dbg1, dbg3;

    assign bus1.req_valid  = req_valid && !sel;
    assign bus3.req_valid  = req_valid && sel;
    assign bus1.req_addr   = req_addr;
    assign bus3.req_addr   = req_addr;
    assign bus1.req_funct3 = req_funct3;
    assign bus3.req_funct3 = req_funct3;
    assign bus1.resp_ready = resp_ready && !sel;
    assign bus3.resp_ready = resp_ready && sel;

    dmem_load_unit #(.bits(32), .addr_width_DMEM(10), .MEM_LATENCY(1)) dut1 (
        .clk(clk), .async_reset(rst), .bus(bus1.slave), .state_dbg(dbg1));
    dmem_load_unit #(.bits(32), .addr_width_DMEM(10), .MEM_LATENCY(3)) dut3 (
        .clk(clk), .async_reset(rst), .bus(bus3.slave), .state_dbg(dbg3));

    // DMEM models: read data is valid only in the one cycle MEM_LATENCY after the strobe.
    logic [31:0] m1_q;
    logic [31:0] p3 [3];
    always @(posedge clk) begin
        m1_q  <= bus1.mem_en ? mem[bus1.mem_addr] : 32'hDEAD_BEEF;
        p3[0] <= bus3.mem_en ? mem[bus3.mem_addr] : 32'hDEAD_BEEF;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign bus1.mem_rdata = m1_q;
    assign bus3.mem_rdata = p3[2];

    // Observation of whichever instance is selected.
    logic        o_req_ready, o_mem_en, o_resp_valid, o_resp_error;
    logic [7:0]  o_mem_addr;
    logic [31:0] o_resp_data;
    assign o_req_ready  = sel ? bus3.req_ready  : bus1.req_ready;
    assign o_mem_en     = sel ? bus3.mem_en     : bus1.mem_en;
    assign o_mem_addr   = sel ? bus3.mem_addr   : bus1.mem_addr;
    assign o_resp_valid = sel ? bus3.resp_valid : bus1.resp_valid;
    assign o_resp_data  = sel ? bus3.resp_data  : bus1.resp_data;
    assign o_resp_error = sel ? bus3.resp_error : bus1.resp_error;

    function automatic logic [7:0] mem_byte(input int a);
        logic [31:0] w;
        w = mem[a / 4];
        return w[8 * (a % 4) +: 8];
    endfunction

    // Reference: a load reads 'size' consecutive bytes little-endian from byte memory.
    function automatic void ref_load(input logic [31:0] a, input logic [2:0] f3,
                                     output logic [31:0] d, output logic e, output int nrd);
        int size;
        logic sgn;
        logic [31:0] v;
        d = '0; e = 1'b0; nrd = 0; size = 0; sgn = 1'b0; v = '0;
        case (f3)
            3'b000: begin size = 1; sgn = 1'b1; end
            3'b001: begin size = 2; sgn = 1'b1; end
            3'b010: size = 4;
            3'b100: size = 1;
            3'b101: size = 2;
            default: e = 1'b1;
        endcase
        if (a >= 32'd1024) e = 1'b1;
        if (!e) begin
            nrd = 1;
            if ((int'(a[1:0]) % size) != 0) begin
`ifdef DMEM_LOAD_SPLIT_EN
                if ((int'(a) / 4) + 1 >= 256) e = 1'b1;
                else nrd = 2;
`else
                e = 1'b1;
`endif
            end
        end
        if (e) begin
            nrd = 0;
            return;
        end
        for (int i = 0; i < size; i++)
            v = v | (32'(mem_byte(int'(a) + i)) << (8 * i));
        if (sgn && v[8 * size - 1])
            v = v | (32'hFFFF_FFFF << (8 * size));
        d = v;
    endfunction

    task automatic do_load(input bit s, input logic [31:0] a, input logic [2:0] f3,
                           input logic [31:0] exp_d, input logic exp_e, input int exp_lat,
                           input int exp_nrd, input string name);
        int k, lat, n_en, first_en;
        logic [7:0] en_addr;
        @(posedge clk); #1;
        sel = s;
        #0;
        n_checks++;
        if (o_req_ready !== 1'b1) $display("FAIL %s req_ready idle: got %b want 1", name, o_req_ready);
        else n_pass++;
        req_addr = a; req_funct3 = f3; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        k = 1; lat = -1; n_en = 0; first_en = -1; en_addr = '0;
        while (k <= 30 && lat < 0) begin
            if (o_mem_en === 1'b1) begin
                n_en++;
                if (first_en < 0) begin first_en = k; en_addr = o_mem_addr; end
            end
            if (o_resp_valid === 1'b1) lat = k;
            else begin @(posedge clk); #1; k++; end
        end
        n_checks++;
        if (lat != exp_lat) $display("FAIL %s latency a=%h f3=%0d: got %0d want %0d", name, a, f3, lat, exp_lat);
        else n_pass++;
        n_checks++;
        if (o_resp_data !== exp_d || o_resp_error !== exp_e)
            $display("FAIL %s result a=%h f3=%0d: got %h/%b want %h/%b", name, a, f3, o_resp_data, o_resp_error, exp_d, exp_e);
        else n_pass++;
        n_checks++;
        if (n_en != exp_nrd) $display("FAIL %s mem_en pulses: got %0d want %0d", name, n_en, exp_nrd);
        else n_pass++;
        if (exp_nrd > 0) begin
            n_checks++;
            if (first_en != 1 || en_addr !== a[9:2])
                $display("FAIL %s first read: cycle %0d addr %h want cycle 1 addr %h", name, first_en, en_addr, a[9:2]);
            else n_pass++;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        n_checks++;
        if (o_req_ready !== 1'b1 || o_resp_valid !== 1'b0)
            $display("FAIL %s after handshake: req_ready=%b resp_valid=%b want 1/0", name, o_req_ready, o_resp_valid);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (dbg1 !== IDLE || bus1.req_ready !== 1'b1 || bus1.mem_en !== 1'b0 || bus1.mem_addr !== 8'h00 ||
            bus1.resp_valid !== 1'b0 || bus1.resp_data !== 32'h0 || bus1.resp_error !== 1'b0)
            $display("FAIL reset values: st=%0d rr=%b en=%b ma=%h rv=%b rd=%h re=%b", dbg1, bus1.req_ready,
                     bus1.mem_en, bus1.mem_addr, bus1.resp_valid, bus1.resp_data, bus1.resp_error);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_directed();
        do_load(1'b0, 32'h0D, F3_LB,  32'hFFFF_FFF0, 1'b0, 3, 1, "lb_0d");
        do_load(1'b0, 32'h0C, F3_LBU, 32'h0000_00A5, 1'b0, 3, 1, "lbu_0c");
        do_load(1'b0, 32'h0E, F3_LHU, 32'h0000_8070, 1'b0, 3, 1, "lhu_0e");
        do_load(1'b0, 32'h0E, F3_LH,  32'hFFFF_8070, 1'b0, 3, 1, "lh_0e");
        do_load(1'b0, 32'h0C, F3_LW,  32'h8070_F0A5, 1'b0, 3, 1, "lw_0c");
        do_load(1'b1, 32'h0C, F3_LW,  32'h8070_F0A5, 1'b0, 5, 1, "lw_lat3");
    endtask

    task automatic test_errors();
`ifdef DMEM_LOAD_SPLIT_EN
        do_load(1'b0, 32'h0E, F3_LW, 32'h3344_8070, 1'b0, 5, 2, "lw_split");
        do_load(1'b0, 32'h3FE, F3_LW, 32'h0, 1'b1, 1, 0, "split_off_end");
`else
        do_load(1'b0, 32'h0E, F3_LW, 32'h0, 1'b1, 1, 0, "lw_misaligned");
        do_load(1'b0, 32'h0D, F3_LH, 32'h0, 1'b1, 1, 0, "lh_misaligned");
`endif
        do_load(1'b0, 32'h1000, F3_LW, 32'h0, 1'b1, 1, 0, "out_of_range");
        do_load(1'b0, 32'h400, F3_LB, 32'h0, 1'b1, 1, 0, "range_edge");
        do_load(1'b0, 32'h0C, 3'b011, 32'h0, 1'b1, 1, 0, "illegal_f3");
    endtask

    task automatic test_boundary();
        logic [31:0] d;
        logic e;
        int nrd;
        ref_load(32'h3FC, F3_LW, d, e, nrd);
        do_load(1'b0, 32'h3FC, F3_LW, d, e, 3, nrd, "lw_last_word");
        ref_load(32'h3FF, F3_LBU, d, e, nrd);
        do_load(1'b0, 32'h3FF, F3_LBU, d, e, 3, nrd, "lbu_last_byte");
    endtask

    task automatic test_backpressure();
        int k;
        @(posedge clk); #1;
        sel = 1'b0;
        req_addr = 32'h0C; req_funct3 = F3_LW; req_valid = 1'b1;
        @(posedge clk); #1;
        k = 0;
        while (o_resp_valid !== 1'b1 && k < 10) begin
            n_checks++;
            if (o_req_ready !== 1'b0) $display("FAIL bp busy req_ready: got %b want 0", o_req_ready);
            else n_pass++;
            @(posedge clk); #1; k++;
        end
        repeat (5) begin
            n_checks++;
            if (o_resp_valid !== 1'b1 || o_resp_data !== 32'h8070_F0A5 || o_req_ready !== 1'b0)
                $display("FAIL bp hold: rv=%b rd=%h rr=%b want 1/8070f0a5/0", o_resp_valid, o_resp_data, o_req_ready);
            else n_pass++;
            @(posedge clk); #1;
        end
        req_valid = 1'b0; resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        n_checks++;
        if (o_req_ready !== 1'b1 || o_resp_valid !== 1'b0)
            $display("FAIL bp release: rr=%b rv=%b want 1/0", o_req_ready, o_resp_valid);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit seen;
        @(posedge clk); #1;
        sel = 1'b1;
        req_addr = 32'h0C; req_funct3 = F3_LW; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (dbg3 !== WAIT) $display("FAIL mid reset setup state: got %0d want %0d", dbg3, WAIT);
        else n_pass++;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if (dbg3 !== IDLE || o_req_ready !== 1'b1 || o_mem_en !== 1'b0 || o_mem_addr !== 8'h00 ||
            o_resp_valid !== 1'b0 || o_resp_data !== 32'h0 || o_resp_error !== 1'b0)
            $display("FAIL mid reset values: st=%0d rr=%b en=%b rv=%b rd=%h re=%b", dbg3, o_req_ready,
                     o_mem_en, o_resp_valid, o_resp_data, o_resp_error);
        else n_pass++;
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (o_resp_valid === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen) $display("FAIL mid reset response: got resp_valid want none");
        else n_pass++;
    endtask

    task automatic test_random(input bit s, input int n);
        logic [31:0] a, d;
        logic [2:0] f;
        logic e;
        int nrd, lat, lmem, r;
        lmem = s ? 3 : 1;
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0) a = $urandom();
            else a = 32'($urandom_range(0, 1023));
            if (r >= 6) a[1:0] = 2'b00;
            if ($urandom_range(0, 9) == 0) f = 3'($urandom_range(0, 7));
            else f = legal[$urandom_range(0, 4)];
            ref_load(a, f, d, e, nrd);
            lat = e ? 1 : ((nrd == 2) ? 2 * (lmem + 1) + 1 : lmem + 2);
            do_load(s, a, f, d, e, lat, nrd, "rand");
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom();
        mem[3] = 32'h8070_F0A5;
        mem[4] = 32'h1122_3344;
        test_reset();
        test_directed();
        test_errors();
        test_boundary();
        test_backpressure();
        test_reset_mid();
        test_random(1'b0, 40);
        test_random(1'b1, 12);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/dmem_load_unit.md
Name: dmem_load_unit

Overview:
- Read-side counterpart to the core's store path and register-file write path.
- Accepts one load request at a time from the execute stage.
- Issues a word read to the synchronous data memory (DMEM), then extracts and sign- or zero-extends the byte, halfword or word.
- Returns the result through a valid/ready handshake for register-file writeback.

Parameters:
- bits, 32, data/address width; only 32 is supported and the funct3 semantics assume it.
- addr_width_DMEM, 10, byte-address width of DMEM; valid byte addresses are 0 .. 2**addr_width_DMEM-1.
- MEM_LATENCY, 1, cycles from mem_en to valid mem_rdata; range 1..4.

Ports:
- clk  input  1  rising-edge clock
- async_reset  input  1  reset, synchronous and active-high despite the name
- req_valid  input  1  load request present
- req_ready  output  1  unit can accept a request; high only in IDLE
- req_addr  input  bits  byte address
- req_funct3  input  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; other codes are illegal
- mem_en  output  1  DMEM read strobe, one-cycle pulse
- mem_addr  output  addr_width_DMEM-2  word address
- mem_rdata  input  bits  DMEM read data
- resp_valid  output  1  result available
- resp_ready  input  1  consumer accepts result
- resp_data  output  bits  extended load result
- resp_error  output  1  misaligned, out-of-range or illegal funct3

Behaviour:
- Reset (async_reset sampled high at a clk edge):
  - state goes to IDLE.
  - req_ready=1, mem_en=0, mem_addr=0, resp_valid=0, resp_data=0, resp_error=0.
  - Reset mid-operation abandons the transaction; no response is produced, and late mem_rdata is ignored.
- States and transitions:
  - IDLE: req_ready=1. Accept on req_valid&&req_ready at edge T; latch addr[1:0], funct3 and word address.
    - If an error is detected, go to RESP with resp_error=1, resp_data=0, and no mem_en.
    - Otherwise go to ISSUE.
  - ISSUE (cycle T+1): mem_en=1 and mem_addr=latched word address for exactly one cycle; load the latency counter with MEM_LATENCY-1; go to WAIT.
  - WAIT: decrement the counter each cycle. When it is 0, capture mem_rdata at that edge, extract, register resp_data, and go to RESP.
  - RESP: resp_valid=1; resp_data and resp_error hold stable until resp_valid&&resp_ready. On handshake go to IDLE; req_ready returns the next cycle, so there is no same-cycle back-to-back acceptance.
- Latency:
  - With MEM_LATENCY=1, the first resp_valid cycle is T+3.
  - An error response appears at T+1.
- Error detection at accept:
  - Misaligned: LH/LHU with addr[0]=1, or LW with addr[1:0]≠0.
  - Out-of-range: req_addr >= 2**addr_width_DMEM, i.e. any set bit above addr_width_DMEM-1.
  - Illegal funct3: any code other than the five listed.
  - If several errors apply, a single resp_error=1 is reported.
- Extraction from word w and byte offset o:
  - Byte = w[8o+7:8o]. LB sign-extends bit 7; LBU zero-extends.
  - Half = w[16(o/2)+15 : 16(o/2)]. LH sign-extends bit 15; LHU zero-extends.
  - LW passes w through unchanged.
- req_ready is low in ISSUE, WAIT and RESP; req_valid in those states is ignored.

Optional Feature:
- Macro: DMEM_LOAD_SPLIT_EN.
- Defined:
  - In-range misaligned LH/LHU/LW is not an error.
  - The unit issues two reads: word N in ISSUE, then word N+1 in an extra ISSUE2/WAIT2 pair.
  - The two words are concatenated as {w(N+1), wN}, shifted right by 8*o, then truncated and extended as usual.
  - Latency is 2*(MEM_LATENCY+1)+1 cycles to resp_valid.
  - If word N+1 exceeds the DMEM range, the response is resp_error=1 with no second read.
- Undefined: misaligned access is an error as described above; ISSUE2 and WAIT2 do not exist.

Decomposition:
- Shared package holds:
  - funct3 load encodings (LB, LH, LW, LBU, LHU);
  - the FSM state enum: IDLE, ISSUE, WAIT, RESP, plus ISSUE2/WAIT2 under the macro;
  - the constant WORD_BYTES=4.
- One sub-module, load_extract: purely combinational word/offset/funct3 → extended data. It is reused by the split path on the shifted 64-bit pair.

Test Plan:
- Reset, then preload DMEM word 3 = 0x8070_F0A5. LB at byte address 0x0D → mem_en one cycle at T+1 with mem_addr=3; resp_valid at T+3; resp_data=0xFFFF_FFF0, resp_error=0.
- Same word: LBU at 0x0C → 0x0000_00A5. LHU at 0x0E → 0x0000_8070. LH at 0x0E → 0xFFFF_8070. LW at 0x0C → 0x8070_F0A5.
- LW at 0x0E with the macro undefined → resp_valid at T+1, resp_error=1, resp_data=0, mem_en never asserted.
- Hold resp_ready=0 for 5 cycles → resp_valid and resp_data stable throughout. req_ready stays 0 while req_valid is held high. After the handshake, req_ready=1 in the next cycle.
- Address 0x0000_1000 with addr_width_DMEM=10 → out-of-range error. With MEM_LATENCY=3, a valid LW gives resp_valid at T+5.
- Assert async_reset during WAIT → the next cycle is IDLE, all outputs at reset values, and no resp_valid ever. With DMEM_LOAD_SPLIT_EN, LW at 0x0E with words 3=0x8070_F0A5 and 4=0x1122_3344 → 0x3344_8070.
